// File: rtl/dmd_frame_mem_if.sv
// Simplified AXI4-Lite pixel-memory bus (AW, W, AR, R; no B channel).
interface dmd_frame_mem_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
);
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata,
           s_axi_arvalid, s_axi_araddr, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_arready, s_axi_rvalid, s_axi_rdata
  );

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata,
           s_axi_arvalid, s_axi_araddr, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_arready, s_axi_rvalid, s_axi_rdata
  );
endinterface

// File: rtl/dmd_frame_mem.sv
// Frame-store responder for the motion detector's pixel-memory master.
// Optional macro DMD_FRAME_MEM_BOUNDS_CHECK_EN: reject out-of-range indices and add sticky oob_err.
module dmd_frame_mem #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic clk,
  input  logic rst,
  dmd_frame_mem_if.slave bus
`ifdef DMD_FRAME_MEM_BOUNDS_CHECK_EN
  ,
  output logic oob_err
`endif
);
  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int IDX_BITS  = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_buf;
  logic [DATA_WIDTH-1:0] w_buf;
  logic                  aw_hs, w_hs, ar_hs, commit, mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_word, rd_word;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [IDX_BITS-1:0]   wr_idx, rd_idx;
  logic                  wr_oob, rd_oob;

  // A buffered channel stays ready only when its partner can complete the pair now.
  assign bus.s_axi_awready = ~rst & (~aw_full | w_full | (bus.s_axi_wvalid & ~w_full));
  assign bus.s_axi_wready  = ~rst & (~w_full | aw_full | (bus.s_axi_awvalid & ~aw_full));
  assign bus.s_axi_arready = ~rst & (~bus.s_axi_rvalid | bus.s_axi_rready);

  assign aw_hs  = bus.s_axi_awvalid & bus.s_axi_awready;
  assign w_hs   = bus.s_axi_wvalid & bus.s_axi_wready;
  assign ar_hs  = bus.s_axi_arvalid & bus.s_axi_arready;
  assign commit = (aw_full | aw_hs) & (w_full | w_hs);

  assign wr_addr = aw_full ? aw_buf : bus.s_axi_awaddr;
  assign wr_data = w_full ? w_buf : bus.s_axi_wdata;
  assign wr_word = wr_addr >> BYTE_BITS;
  assign rd_word = bus.s_axi_araddr >> BYTE_BITS;
  assign wr_idx  = wr_word[IDX_BITS-1:0];
  assign rd_idx  = rd_word[IDX_BITS-1:0];

`ifdef DMD_FRAME_MEM_BOUNDS_CHECK_EN
  assign wr_oob = wr_word >= ADDR_WIDTH'(DEPTH);
  assign rd_oob = rd_word >= ADDR_WIDTH'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_err <= 1'b0;
    end else if ((commit & wr_oob) | (ar_hs & rd_oob)) begin
      oob_err <= 1'b1;
    end
  end
`else
  // Index wraps modulo DEPTH; the upper word-index bits are intentionally dropped.
  logic unused_hi;
  assign unused_hi = ^{wr_word[ADDR_WIDTH-1:IDX_BITS], rd_word[ADDR_WIDTH-1:IDX_BITS]};
  assign wr_oob = 1'b0;
  assign rd_oob = 1'b0;
`endif

  assign mem_we = commit & ~wr_oob;

  // A committing pair frees its slot, but a same-cycle new beat on an already-full channel refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      aw_full <= commit ? (aw_full & aw_hs) : (aw_full | aw_hs);
      w_full  <= commit ? (w_full & w_hs) : (w_full | w_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_buf <= bus.s_axi_awaddr;
    if (w_hs)  w_buf  <= bus.s_axi_wdata;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= wr_data;
  end

  // Read-first: the registered read samples the array before a same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.s_axi_rvalid <= 1'b0;
      bus.s_axi_rdata  <= '0;
    end else if (ar_hs) begin
      bus.s_axi_rvalid <= 1'b1;
      bus.s_axi_rdata  <= rd_oob ? '1 : mem[rd_idx];
    end else if (bus.s_axi_rready) begin
      bus.s_axi_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmd_frame_mem.sv
// Directed self-checking bench for dmd_frame_mem (default DEPTH=4096, 32-bit words).
module tb_dmd_frame_mem;
  localparam int AW = 20;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmd_frame_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef DMD_FRAME_MEM_BOUNDS_CHECK_EN
  logic oob_err;
`endif

  dmd_frame_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMD_FRAME_MEM_BOUNDS_CHECK_EN
    ,
    .oob_err (oob_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // AW and W presented together; both must be accepted on the same edge.
  task automatic write_same(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = addr;
    bus.s_axi_wvalid  = 1'b1; bus.s_axi_wdata  = data;
    #1;
    check_val("wr_same_ready", {bus.s_axi_awready, bus.s_axi_wready}, 2'b11);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    $display("txn write addr=%h data=%h", addr, data);
  endtask

  task automatic read_word(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    @(negedge clk);
    bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = addr; bus.s_axi_rready = 1'b1;
    #1;
    check_val("rd_arready", bus.s_axi_arready, 1);
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    check_val("rd_rvalid", bus.s_axi_rvalid, 1);
    data = bus.s_axi_rdata;
    $display("txn read  addr=%h data=%h", addr, data);
  endtask

  logic [DW-1:0] rd;
  int issued, received, cyc;
  logic exp_rvalid, exp_arready;
  logic [DW-1:0] exp_rdata;

  initial begin
    bus.s_axi_awvalid = 0; bus.s_axi_awaddr = '0; bus.s_axi_wvalid = 0; bus.s_axi_wdata = '0;
    bus.s_axi_arvalid = 0; bus.s_axi_araddr = '0; bus.s_axi_rready = 0;

    // Reset state
    #1;
    check_val("rst_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_rvalid", bus.s_axi_rvalid, 0);
    check_val("rst_rdata", bus.s_axi_rdata, 0);
    check_val("idle_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);

    // AW first, W three cycles later
    @(negedge clk);
    bus.s_axi_awvalid = 1; bus.s_axi_awaddr = 20'h10;
    @(negedge clk);
    bus.s_axi_awvalid = 0;
    #1;
    check_val("aw_held_awready", bus.s_axi_awready, 0);
    check_val("aw_held_wready", bus.s_axi_wready, 1);
    @(negedge clk);
    check_val("aw_held_awready2", bus.s_axi_awready, 0);
    @(negedge clk);
    bus.s_axi_wvalid = 1; bus.s_axi_wdata = 32'hDEADBEEF;
    #1;
    check_val("aw_pair_readies", {bus.s_axi_awready, bus.s_axi_wready}, 2'b11);
    @(negedge clk);
    bus.s_axi_wvalid = 0;
    #1;
    check_val("after_commit_awready", bus.s_axi_awready, 1);
    $display("txn write addr=00010 data=deadbeef (aw first)");
    read_word(20'h10, rd);
    check_val("rd_0x10", rd, 32'hDEADBEEF);

    // W first, then AW
    @(negedge clk);
    bus.s_axi_wvalid = 1; bus.s_axi_wdata = 32'h11;
    @(negedge clk);
    bus.s_axi_wvalid = 0;
    #1;
    check_val("w_held_wready", bus.s_axi_wready, 0);
    @(negedge clk);
    bus.s_axi_awvalid = 1; bus.s_axi_awaddr = 20'h0;
    #1;
    check_val("w_held_awready", bus.s_axi_awready, 1);
    @(negedge clk);
    bus.s_axi_awvalid = 0;
    $display("txn write addr=00000 data=00000011 (w first)");
    write_same(20'h4, 32'h22);
    read_word(20'h0, rd);
    check_val("rd_0x0", rd, 32'h11);
    read_word(20'h4, rd);
    check_val("rd_0x4", rd, 32'h22);

    // Same-edge read and write of one word: read returns the old value
    write_same(20'h20, 32'hA);
    @(negedge clk);
    bus.s_axi_awvalid = 1; bus.s_axi_awaddr = 20'h20;
    bus.s_axi_wvalid  = 1; bus.s_axi_wdata  = 32'hB;
    bus.s_axi_arvalid = 1; bus.s_axi_araddr = 20'h20; bus.s_axi_rready = 1;
    #1;
    check_val("rw_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
    @(negedge clk);
    bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0; bus.s_axi_arvalid = 0;
    check_val("rw_old_data", bus.s_axi_rdata, 32'hA);
    $display("txn rw    addr=00020 wrote=0000000b read=%h", bus.s_axi_rdata);
    read_word(20'h20, rd);
    check_val("rw_new_data", rd, 32'hB);

    // Sustained writes: 64 words, one per cycle
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bus.s_axi_awvalid = 1; bus.s_axi_awaddr = AW'(32'h100 + 4 * i);
      bus.s_axi_wvalid  = 1; bus.s_axi_wdata  = 32'hA500_0000 | i;
      #1;
      check_val("stream_wr_ready", {bus.s_axi_awready, bus.s_axi_wready}, 2'b11);
    end
    @(negedge clk);
    bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
    $display("txn write burst 64 words at 00100");

    // Streaming reads with rready toggling; model tracks expected R state
    issued = 0; received = 0; cyc = 0; exp_rvalid = 0; exp_rdata = '0;
    while (received < 64 && cyc < 400) begin
      bus.s_axi_rready  = (cyc % 2 == 0);
      bus.s_axi_arvalid = (issued < 64);
      bus.s_axi_araddr  = AW'(32'h100 + 4 * issued);
      #1;
      exp_arready = ~exp_rvalid | bus.s_axi_rready;
      check_val("stream_arready", bus.s_axi_arready, exp_arready);
      check_val("stream_rvalid", bus.s_axi_rvalid, exp_rvalid);
      if (exp_rvalid) check_val("stream_rdata", bus.s_axi_rdata, exp_rdata);
      if (exp_rvalid && bus.s_axi_rready) received++;
      if (bus.s_axi_arvalid && exp_arready) begin
        exp_rdata  = 32'hA500_0000 | issued;
        exp_rvalid = 1;
        issued++;
      end else if (bus.s_axi_rready) begin
        exp_rvalid = 0;
      end
      cyc++;
      @(negedge clk);
    end
    bus.s_axi_arvalid = 0; bus.s_axi_rready = 1;
    check_val("stream_received", received, 64);
    $display("txn read burst issued=%0d received=%0d cycles=%0d", issued, received, cyc);

    // Out-of-range address 0x4000 (word 4096)
`ifdef DMD_FRAME_MEM_BOUNDS_CHECK_EN
    check_val("oob_err_clear", oob_err, 0);
    write_same(20'h4000, 32'h77);
    read_word(20'h0, rd);
    check_val("oob_no_write", rd, 32'h11);
    read_word(20'h4000, rd);
    check_val("oob_rdata", rd, 32'hFFFFFFFF);
    check_val("oob_err_set", oob_err, 1);
`else
    read_word(20'h4000, rd);
    check_val("wrap_read", rd, 32'h11);
    write_same(20'h4000, 32'h77);
    read_word(20'h0, rd);
    check_val("wrap_write", rd, 32'h77);
`endif

    // Reset mid-transaction: AW held, R beat pending
    write_same(20'h300, 32'h55);
    @(negedge clk);
    bus.s_axi_awvalid = 1; bus.s_axi_awaddr = 20'h300;
    bus.s_axi_arvalid = 1; bus.s_axi_araddr = 20'h10; bus.s_axi_rready = 0;
    @(negedge clk);
    bus.s_axi_awvalid = 0; bus.s_axi_arvalid = 0;
    check_val("pre_rst_rvalid", bus.s_axi_rvalid, 1);
    rst = 1;
    bus.s_axi_wvalid = 1; bus.s_axi_wdata = 32'h99;
    #1;
    check_val("mid_rst_rvalid", bus.s_axi_rvalid, 0);
    check_val("mid_rst_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 0;
    bus.s_axi_wvalid = 0; bus.s_axi_rready = 1;
    #1;
    check_val("post_rst_awready", bus.s_axi_awready, 1);
    check_val("post_rst_rdata", bus.s_axi_rdata, 0);
`ifdef DMD_FRAME_MEM_BOUNDS_CHECK_EN
    check_val("oob_err_rst", oob_err, 0);
`endif
    $display("txn reset mid-transaction");
    read_word(20'h300, rd);
    check_val("rst_word_kept", rd, 32'h55);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
